// File: rtl/wshb_arbiter_n.sv
// N-master to 1-slave Wishbone arbiter with fixed-priority or round-robin selection,
// a registered one-hot grant and optional ack-quantum preemption via rty.
module wshb_arbiter_n #(
    parameter int unsigned N       = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned RR      = 1,
    parameter int unsigned QUANTUM = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N-1:0]            m_cyc,
    input  logic [N-1:0]            m_stb,
    input  logic [N-1:0]            m_we,
    input  logic [N*AW-1:0]         m_adr,
    input  logic [N*DW-1:0]         m_dat_ms,
    input  logic [N*(DW/8)-1:0]     m_sel,
    input  logic [N*3-1:0]          m_cti,
    input  logic [N*2-1:0]          m_bte,
    output logic [N-1:0]            m_ack,
    output logic [N-1:0]            m_err,
    output logic [N-1:0]            m_rty,
    output logic [N*DW-1:0]         m_dat_sm,
    output logic                    s_cyc,
    output logic                    s_stb,
    output logic                    s_we,
    output logic [AW-1:0]           s_adr,
    output logic [DW-1:0]           s_dat_ms,
    output logic [DW/8-1:0]         s_sel,
    output logic [2:0]              s_cti,
    output logic [1:0]              s_bte,
    input  logic                    s_ack,
    input  logic                    s_err,
    input  logic                    s_rty,
    input  logic [DW-1:0]           s_dat_sm,
    output logic [N-1:0]            gnt,
    output logic [$clog2(N)-1:0]    gnt_idx
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned SW = DW / 8;
    localparam int unsigned CW = (QUANTUM > 0) ? $clog2(QUANTUM + 1) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StPreempt} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]   gnt_idx_q, gnt_idx_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [IW-1:0]   win;
    logic            found;
    int unsigned     cand;
    logic [31:0]     gi;
    logic            cyc_g;
    logic            others;

    assign gi     = 32'(gnt_idx_q);
    assign cyc_g  = m_cyc[gi];
    assign others = |(m_cyc & ~gnt_q);

    // Round-robin searches ptr+1, ptr+2, ... so the last winner is considered last.
    always_comb begin
        win   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < N; k++) begin
            if (RR != 0) begin
                cand = (32'(ptr_q) + 1 + k) % N;
            end else begin
                cand = k;
            end
            if (!found && m_cyc[cand]) begin
                found = 1'b1;
                win   = IW'(cand);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (|m_cyc) begin
                    state_d   = StBusy;
                    gnt_d     = N'(1) << win;
                    gnt_idx_d = win;
                    ptr_d     = win;
                    cnt_d     = '0;
                end
            end
            StBusy: begin
                if (QUANTUM != 0 && s_ack && cnt_q != CW'(QUANTUM)) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (!cyc_g) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                end else if (QUANTUM != 0 && s_ack && cnt_d == CW'(QUANTUM) && others) begin
                    state_d = StPreempt;
                end
            end
            StPreempt: begin
                if (!cyc_g) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            ptr_q     <= IW'(N - 1);
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_ms = '0;
        s_sel    = '0;
        s_cti    = '0;
        s_bte    = '0;
        m_ack    = '0;
        m_err    = '0;
        m_rty    = '0;
        m_dat_sm = '0;
        if (state_q == StBusy) begin
            s_cyc    = m_cyc[gi];
            s_stb    = m_stb[gi];
            s_we     = m_we[gi];
            s_adr    = m_adr[gi*AW +: AW];
            s_dat_ms = m_dat_ms[gi*DW +: DW];
            s_sel    = m_sel[gi*SW +: SW];
            s_cti    = m_cti[gi*3 +: 3];
            s_bte    = m_bte[gi*2 +: 2];
            m_ack[gi] = s_ack;
            m_err[gi] = s_err;
            m_rty[gi] = s_rty;
            m_dat_sm[gi*DW +: DW] = s_dat_sm;
        end else if (state_q == StPreempt) begin
            // Slave is detached; every new strobe from the preempted master is told to retry.
            m_rty[gi] = m_stb[gi];
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;

endmodule
